// File: rtl/ddr3_init_pkg.sv
// Shared encodings for the DDR3 power-up sequencer: FSM states, command pin
// patterns {cs_n,ras_n,cas_n,we_n}, mode register indices and the ZQCL A10 bit.
package ddr3_init_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_RST_HOLD = 4'd1;
    localparam logic [3:0] ST_CKE_WAIT = 4'd2;
    localparam logic [3:0] ST_XPR      = 4'd3;
    localparam logic [3:0] ST_MRS2     = 4'd4;
    localparam logic [3:0] ST_MRS3     = 4'd5;
    localparam logic [3:0] ST_MRS1     = 4'd6;
    localparam logic [3:0] ST_MRS0     = 4'd7;
    localparam logic [3:0] ST_ZQCL     = 4'd8;
    localparam logic [3:0] ST_DONE     = 4'd9;

    localparam logic [3:0] CMD_DES  = 4'b1111;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;

    localparam logic [2:0] MR0_IDX = 3'd0;
    localparam logic [2:0] MR1_IDX = 3'd1;
    localparam logic [2:0] MR2_IDX = 3'd2;
    localparam logic [2:0] MR3_IDX = 3'd3;

    localparam int ZQ_A10_BIT = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_init_timer.sv
// Loadable down-counter for state durations; saturates at zero.
// Load wins over decrement; o_zero is combinational from the count register.
module ddr3_init_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ddr3_init_seq.sv
// DDR3 JEDEC power-up sequencer: RESET#/CKE timing, MR2/MR3/MR1/MR0, ZQCL, tZQinit.
// Latency start->done = sum of phase lengths; no backpressure, init_start ignored while busy.
module ddr3_init_seq
    import ddr3_init_pkg::*;
#(
    parameter int MEM_A_WIDTH  = 15,
    parameter int T_RESET_CYC  = 20000,
    parameter int T_CKE_CYC    = 50000,
    parameter int T_XPR_CYC    = 27,
    parameter int T_MRD_CYC    = 4,
    parameter int T_MOD_CYC    = 12,
    parameter int T_ZQINIT_CYC = 512,
    parameter logic [MEM_A_WIDTH-1:0] MR0_VAL = '0,
    parameter logic [MEM_A_WIDTH-1:0] MR1_VAL = '0,
    parameter logic [MEM_A_WIDTH-1:0] MR2_VAL = '0,
    parameter logic [MEM_A_WIDTH-1:0] MR3_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_start,
    output logic                   init_busy,
    output logic                   init_done,
    output logic                   mem_reset_n,
    output logic                   mem_cke,
    output logic                   mem_cs_n,
    output logic                   mem_ras_n,
    output logic                   mem_cas_n,
    output logic                   mem_we_n,
    output logic [MEM_A_WIDTH-1:0] mem_a,
    output logic [2:0]             mem_ba,
    output logic                   mem_odt
);

    localparam int T_MAX = max_int(max_int(max_int(T_RESET_CYC, T_CKE_CYC),
                                           max_int(T_XPR_CYC, T_MRD_CYC)),
                                   max_int(T_MOD_CYC, T_ZQINIT_CYC));
    localparam int CW = $clog2(T_MAX) + 1;

    logic [3:0]             r_state;
    logic [3:0]             w_next_state;
    logic                   w_enter;
    logic                   w_zero;
    logic [CW-1:0]          w_load_val;

    logic                   w_reset_n;
    logic                   w_cke;
    logic [3:0]             w_cmd;
    logic [MEM_A_WIDTH-1:0] w_a;
    logic [2:0]             w_ba;
    logic                   w_busy;
    logic                   w_done;

    logic                   r_reset_n;
    logic                   r_cke;
    logic [3:0]             r_cmd;
    logic [MEM_A_WIDTH-1:0] r_a;
    logic [2:0]             r_ba;
    logic                   r_busy;
    logic                   r_done;

    ddr3_init_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_enter),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // The timer holds N-1 on the first cycle of a state, so w_zero marks its last cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (init_start) w_next_state = ST_RST_HOLD;
            ST_RST_HOLD:      if (w_zero)     w_next_state = ST_CKE_WAIT;
            ST_CKE_WAIT:      if (w_zero)     w_next_state = ST_XPR;
            ST_XPR:           if (w_zero)     w_next_state = ST_MRS2;
            ST_MRS2:          if (w_zero)     w_next_state = ST_MRS3;
            ST_MRS3:          if (w_zero)     w_next_state = ST_MRS1;
            ST_MRS1:          if (w_zero)     w_next_state = ST_MRS0;
            ST_MRS0:          if (w_zero)     w_next_state = ST_ZQCL;
            ST_ZQCL:          if (w_zero)     w_next_state = ST_DONE;
            default:                          w_next_state = ST_IDLE;
        endcase
    end

    assign w_enter = (w_next_state != r_state);

    always_comb begin
        w_load_val = '0;
        case (w_next_state)
            ST_RST_HOLD: w_load_val = CW'(T_RESET_CYC - 1);
            ST_CKE_WAIT: w_load_val = CW'(T_CKE_CYC - 1);
            ST_XPR:      w_load_val = CW'(T_XPR_CYC - 1);
            ST_MRS2, ST_MRS3, ST_MRS1:
                         w_load_val = CW'(T_MRD_CYC - 1);
            ST_MRS0:     w_load_val = CW'(T_MOD_CYC - 1);
            ST_ZQCL:     w_load_val = CW'(T_ZQINIT_CYC - 1);
            default:     w_load_val = '0;
        endcase
    end

    // Pin values are decoded from the state being entered so they are registered
    // alongside the state; the MRS/ZQCL command only appears on the entry cycle.
    always_comb begin
        w_reset_n = 1'b1;
        w_cke     = 1'b1;
        w_cmd     = CMD_NOP;
        w_a       = '0;
        w_ba      = '0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        case (w_next_state)
            ST_IDLE: begin
                w_reset_n = 1'b0;
                w_cke     = 1'b0;
                w_cmd     = CMD_DES;
                w_busy    = 1'b0;
            end
            ST_RST_HOLD: begin
                w_reset_n = 1'b0;
                w_cke     = 1'b0;
                w_cmd     = CMD_DES;
            end
            ST_CKE_WAIT: begin
                w_cke = 1'b0;
                w_cmd = CMD_DES;
            end
            ST_MRS2: if (w_enter) begin w_cmd = CMD_MRS; w_ba = MR2_IDX; w_a = MR2_VAL; end
            ST_MRS3: if (w_enter) begin w_cmd = CMD_MRS; w_ba = MR3_IDX; w_a = MR3_VAL; end
            ST_MRS1: if (w_enter) begin w_cmd = CMD_MRS; w_ba = MR1_IDX; w_a = MR1_VAL; end
            ST_MRS0: if (w_enter) begin w_cmd = CMD_MRS; w_ba = MR0_IDX; w_a = MR0_VAL; end
            ST_ZQCL: if (w_enter) begin
                w_cmd             = CMD_ZQCL;
                w_a[ZQ_A10_BIT]   = 1'b1;
            end
            ST_DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_reset_n <= 1'b0;
            r_cke     <= 1'b0;
            r_cmd     <= CMD_DES;
            r_a       <= '0;
            r_ba      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_reset_n <= w_reset_n;
            r_cke     <= w_cke;
            r_cmd     <= w_cmd;
            r_a       <= w_a;
            r_ba      <= w_ba;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign init_busy   = r_busy;
    assign init_done   = r_done;
    assign mem_reset_n = r_reset_n;
    assign mem_cke     = r_cke;
    assign {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n} = r_cmd;
    assign mem_a       = r_a;
    assign mem_ba      = r_ba;
    assign mem_odt     = 1'b0;

endmodule
